// File: rtl/aes_round_engine.sv
// Iterative AES-128 encryption engine: one round per clock, round keys fetched
// from an external key schedule through SelKey (key sampled one edge after the
// index is driven). Optional sticky error flag enabled by AES_ROUND_ENGINE_ERR_EN.
module aes_round_engine #(
    parameter int unsigned KEY_TIMEOUT = 255,  // WAIT_KEY abort limit, 1..65535
    parameter int unsigned NR          = 10    // round count; only 10 is legal
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         Start,
    input  logic [127:0] DataIn,
    input  logic [127:0] Key,
    input  logic         KeyRy,
    output logic [3:0]   SelKey,
    output logic [127:0] DataOut,
    output logic         Busy,
    output logic         Done
`ifdef AES_ROUND_ENGINE_ERR_EN
    ,
    output logic         Err
`endif
);

    localparam int unsigned DW = 128;
    localparam int unsigned RW = 4;
    localparam int unsigned TW = 16;
    localparam logic [TW-1:0] TMO_LAST  = TW'(KEY_TIMEOUT - 1);
    localparam logic [RW-1:0] RND_LAST  = RW'(NR - 1);

    localparam logic [7:0] SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_KEY, S_ADD0, S_ROUND, S_FINAL, S_DONE
    } state_e;

    // Multiply by x in GF(2^8) modulo 0x11B
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // SubBytes followed by ShiftRows; byte i sits at row i%4, column i/4
    function automatic logic [DW-1:0] sub_shift(input logic [DW-1:0] s);
        logic [DW-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = SBOX[s[127-8*(4*((c+r)%4)+r) -: 8]];
            end
        end
        return o;
    endfunction

    // MixColumns over the four state columns
    function automatic logic [DW-1:0] mix_cols(input logic [DW-1:0] s);
        logic [DW-1:0] o;
        logic [7:0]    a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    state_e        st_q;
    logic [DW-1:0] blk_q;
    logic [RW-1:0] rnd_q;
    logic [TW-1:0] tmo_q;
    logic [DW-1:0] sr_d;
    logic [DW-1:0] rnd_d;
    logic [DW-1:0] fin_d;

    // Round datapath: full round and final (no MixColumns) round results
    always_comb begin
        sr_d  = sub_shift(blk_q);
        rnd_d = mix_cols(sr_d) ^ Key;
        fin_d = sr_d ^ Key;
    end

    // Control FSM, round state, key index and registered outputs
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            st_q    <= S_IDLE;
            blk_q   <= '0;
            rnd_q   <= '0;
            tmo_q   <= '0;
            SelKey  <= '0;
            DataOut <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
`ifdef AES_ROUND_ENGINE_ERR_EN
            Err     <= 1'b0;
`endif
        end else begin
            Done <= 1'b0;
            case (st_q)
                S_IDLE: begin
                    if (Start) begin
                        blk_q  <= DataIn;
                        Busy   <= 1'b1;
                        SelKey <= '0;
                        tmo_q  <= '0;
                        st_q   <= KeyRy ? S_ADD0 : S_WAIT_KEY;
                    end else begin
                        Busy <= 1'b0;
                    end
                end
                S_WAIT_KEY: begin
                    if (KeyRy) begin
                        st_q <= S_ADD0;
                    end else if (tmo_q == TMO_LAST) begin
                        st_q <= S_IDLE;
                        Busy <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q + 16'd1;
                    end
                end
                S_ADD0: begin
                    blk_q  <= blk_q ^ Key;
                    SelKey <= 4'd1;
                    rnd_q  <= 4'd1;
                    st_q   <= S_ROUND;
                end
                S_ROUND: begin
                    blk_q  <= rnd_d;
                    SelKey <= rnd_q + 4'd1;
                    rnd_q  <= rnd_q + 4'd1;
                    if (rnd_q == RND_LAST) begin
                        st_q <= S_FINAL;
                    end
                end
                S_FINAL: begin
                    DataOut <= fin_d;
                    st_q    <= S_DONE;
                end
                S_DONE: begin
                    Done   <= 1'b1;
                    SelKey <= '0;
                    st_q   <= S_IDLE;
                end
                default: st_q <= S_IDLE;
            endcase
`ifdef AES_ROUND_ENGINE_ERR_EN
            if (st_q == S_IDLE) begin
                if (Start) begin
                    Err <= 1'b0;
                end
            end else if (Start
                         || (!KeyRy && (st_q inside {S_ADD0, S_ROUND, S_FINAL}))
                         || (st_q == S_WAIT_KEY && !KeyRy && tmo_q == TMO_LAST)) begin
                Err <= 1'b1;
            end
`endif
        end
    end

endmodule

// File: tb/tb_aes_round_engine.sv
// Bench for aes_round_engine: transaction-level AES model (S-box derived from
// GF(2^8) inversion), per-cycle output compare, directed FIPS vectors, random ops.
module tb_aes_round_engine;

    logic         Clk;
    logic         Rst;
    logic         Start, Start2;
    logic [127:0] DataIn;
    logic [127:0] Key, Key2;
    logic         KeyRy, KeyRy2;
    logic [3:0]   SelKey, SelKey2;
    logic [127:0] DataOut, DataOut2;
    logic         Busy, Busy2;
    logic         Done, Done2;
`ifdef AES_ROUND_ENGINE_ERR_EN
    logic         Err, Err2;
`endif

    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 0;

    logic [7:0]   sbox_t [256];
    logic [127:0] rk_arr [16];
    logic [127:0] cur_key;

    assign Key  = rk_arr[SelKey];
    assign Key2 = rk_arr[SelKey2];

    aes_round_engine u_dut (
        .Clk(Clk), .Rst(Rst), .Start(Start), .DataIn(DataIn), .Key(Key), .KeyRy(KeyRy),
        .SelKey(SelKey), .DataOut(DataOut), .Busy(Busy), .Done(Done)
`ifdef AES_ROUND_ENGINE_ERR_EN
        , .Err(Err)
`endif
    );

    aes_round_engine #(.KEY_TIMEOUT(8)) u_to (
        .Clk(Clk), .Rst(Rst), .Start(Start2), .DataIn(DataIn), .Key(Key2), .KeyRy(KeyRy2),
        .SelKey(SelKey2), .DataOut(DataOut2), .Busy(Busy2), .Done(Done2)
`ifdef AES_ROUND_ENGINE_ERR_EN
        , .Err(Err2)
`endif
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = '0; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    // S-box from multiplicative inverse plus affine map
    task automatic build_sbox();
        for (int a = 0; a < 256; a++) begin
            logic [7:0] inv, b;
            inv = '0;
            for (int x = 1; x < 256; x++)
                if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
            b = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
                ^ {inv[3:0], inv[7:4]} ^ 8'h63;
            sbox_t[a] = b;
        end
    endtask

    function automatic logic [127:0] round_key(input logic [127:0] k, input int n);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
    endfunction

    function automatic logic [127:0] aes_enc(input logic [127:0] k, input logic [127:0] pt);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [7:0]   coef [4];
        logic [7:0]   acc;
        logic [127:0] rk, o;
        coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        rk = round_key(k, 0);
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[127-8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++)
                t[i] = sbox_t[s[(i%4) + 4*(((i/4) + (i%4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                for (int r = 0; r < 4; r++) begin
                    acc = '0;
                    for (int j = 0; j < 4; j++) acc ^= gmul(coef[(j - r + 4) % 4], t[4*c+j]);
                    s[4*c+r] = (rnd == 10) ? t[4*c+r] : acc;
                end
            end
            rk = round_key(k, rnd);
            for (int i = 0; i < 16; i++) s[i] ^= rk[127-8*i -: 8];
        end
        o = '0;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
        return o;
    endfunction

    task automatic set_key(input logic [127:0] k);
        cur_key = k;
        for (int i = 0; i < 16; i++) rk_arr[i] = (i <= 10) ? round_key(k, i) : '0;
    endtask

    // Transaction model: m_t = edges since accept, m_k = edge KeyRy was first seen
    bit           m_busy = 0;
    int           m_t    = 0;
    int           m_k    = -1;
    logic [127:0] m_ct   = '0;
    logic [127:0] m_out  = '0;
    bit           m_err  = 0;

    always @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            m_busy = 0; m_t = 0; m_k = -1; m_out = '0; m_err = 0;
        end else begin
            if (m_busy) begin
                m_t++;
                if (m_k < 0 && KeyRy) m_k = m_t;
                if (m_k >= 0 && m_t >= m_k + 1 && m_t <= m_k + 11 && !KeyRy) m_err = 1;
                if (m_k >= 0 && m_t == m_k + 11) m_out = m_ct;
                if (m_k >= 0 && m_t == m_k + 13) m_busy = 0;
            end
            if (m_busy && Start) begin
                m_err = 1;
            end else if (!m_busy && Start) begin
                m_busy = 1; m_t = 0; m_k = KeyRy ? 0 : -1; m_err = 0;
                m_ct = aes_enc(cur_key, DataIn);
            end
        end
    end

    function automatic logic [3:0] exp_sel();
        int d;
        if (!m_busy || m_k < 0) return 4'd0;
        d = m_t - m_k;
        if (d >= 1 && d <= 10) return 4'(d);
        if (d == 11) return 4'd10;
        return 4'd0;
    endfunction

    // Per-cycle compare of the main instance against the model
    always @(negedge Clk) begin
        if (cmp_en && Rst) begin
            check("busy", 128'(Busy), 128'(m_busy));
            check("done", 128'(Done), 128'(m_busy && m_k >= 0 && m_t == m_k + 12));
            check("selkey", 128'(SelKey), 128'(exp_sel()));
            check("dataout", DataOut, m_out);
`ifdef AES_ROUND_ENGINE_ERR_EN
            check("err", 128'(Err), 128'(m_err));
`endif
        end
    end

    // One encryption on the main instance; d = edges KeyRy stays low after accept
    task automatic run_op(input logic [127:0] k, input logic [127:0] pt, input int d,
                          input int poke, input bit b2b, input logic [127:0] exp);
        int lat;
        if (!b2b) @(negedge Clk);
        set_key(k);
        DataIn = pt; Start = 1'b1; KeyRy = (d == 0);
        @(negedge Clk);
        Start = 1'b0; lat = 0;
        while (Done !== 1'b1 && lat < 400) begin
            if (lat + 1 >= d) KeyRy = 1'b1;
            Start = (lat == poke);
            if (lat == poke) DataIn = {$urandom, $urandom, $urandom, $urandom};
            @(negedge Clk);
            lat++;
        end
        Start = 1'b0;
        check("latency", 128'(lat), 128'(d + 12));
        check("result", DataOut, exp);
    endtask

    initial begin
        logic [127:0] k, p;
        int lat, gap, d, poke;
        Rst = 1'b1; Start = 1'b0; Start2 = 1'b0; KeyRy = 1'b1; KeyRy2 = 1'b1; DataIn = '0;
        build_sbox();
        set_key(B_KEY);
        #2 Rst = 1'b0;
        #1;
        check("rst_busy", 128'(Busy), 128'(0));
        check("rst_done", 128'(Done), 128'(0));
        check("rst_selkey", 128'(SelKey), 128'(0));
        check("rst_dataout", DataOut, 128'(0));
`ifdef AES_ROUND_ENGINE_ERR_EN
        check("rst_err", 128'(Err), 128'(0));
`endif
        check("model_sbox00", 128'(sbox_t[8'h00]), 128'(8'h63));
        check("model_sbox53", 128'(sbox_t[8'h53]), 128'(8'hed));
        check("model_rk10", round_key(B_KEY, 10), 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("model_appb", aes_enc(B_KEY, B_PT), B_CT);
        check("model_c1", aes_enc(C_KEY, C_PT), C_CT);
        repeat (2) @(negedge Clk);
        Rst = 1'b1; cmp_en = 1;

        // FIPS vectors, back-to-back, slow key ready, ignored Start
        run_op(B_KEY, B_PT, 0, -1, 0, B_CT);
        run_op(C_KEY, C_PT, 0, -1, 0, C_CT);
        run_op(B_KEY, B_PT, 0, -1, 1, B_CT);
        run_op(B_KEY, B_PT, 20, -1, 0, B_CT);
        run_op(B_KEY, B_PT, 0, 4, 0, B_CT);
        repeat (2) @(negedge Clk);

        // Key-ready timeout on the short-timeout instance
        @(negedge Clk);
        set_key(B_KEY);
        DataIn = B_PT; Start2 = 1'b1; KeyRy2 = 1'b1;
        @(negedge Clk);
        Start2 = 1'b0; lat = 0;
        while (Done2 !== 1'b1 && lat < 400) begin @(negedge Clk); lat++; end
        check("to_first_lat", 128'(lat), 128'(12));
        check("to_first_ct", DataOut2, B_CT);
        @(negedge Clk);
        DataIn = C_PT; Start2 = 1'b1; KeyRy2 = 1'b0;
        @(negedge Clk);
        Start2 = 1'b0;
        check("to_busy0", 128'(Busy2), 128'(1));
        for (int i = 1; i <= 8; i++) begin
            @(negedge Clk);
            check("to_busy", 128'(Busy2), 128'(i < 8));
            check("to_done", 128'(Done2), 128'(0));
        end
        repeat (4) begin
            @(negedge Clk);
            check("to_idle_done", 128'(Done2), 128'(0));
            check("to_idle_busy", 128'(Busy2), 128'(0));
        end
        check("to_dataout", DataOut2, B_CT);
`ifdef AES_ROUND_ENGINE_ERR_EN
        check("to_err", 128'(Err2), 128'(1));
`endif

        // Asynchronous reset in the middle of round 5
        @(negedge Clk);
        set_key(B_KEY);
        DataIn = B_PT; Start = 1'b1; KeyRy = 1'b1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (5) @(negedge Clk);
        #2 Rst = 1'b0;
        #1;
        check("mid_rst_busy", 128'(Busy), 128'(0));
        check("mid_rst_done", 128'(Done), 128'(0));
        check("mid_rst_selkey", 128'(SelKey), 128'(0));
        check("mid_rst_dataout", DataOut, 128'(0));
`ifdef AES_ROUND_ENGINE_ERR_EN
        check("mid_rst_err", 128'(Err), 128'(0));
`endif
        @(negedge Clk);
        Rst = 1'b1;
        run_op(C_KEY, C_PT, 0, -1, 0, C_CT);

        // Random keys, blocks, key-ready delays, gaps and stray Starts
        for (int n = 0; n < 20; n++) begin
            k = {$urandom, $urandom, $urandom, $urandom};
            p = {$urandom, $urandom, $urandom, $urandom};
            d = $urandom_range(0, 4);
            gap = $urandom_range(0, 2);
            poke = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 10)) : -1;
            if (gap > 1) repeat (gap - 1) @(negedge Clk);
            run_op(k, p, d, poke, (gap == 0), aes_enc(k, p));
        end

        repeat (3) @(negedge Clk);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
